// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: shadows dst/Tnew of E, M, W, raises stall/bubble,
// picks branch-compare forwarding sources and runs the mult/div busy counter.
module hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [1:0] id_rs_tuse,
  input  logic [1:0] id_rt_tuse,
  input  logic [4:0] id_dst,
  input  logic [1:0] id_tnew,
  input  logic       id_md_start,
  input  logic       id_md_div,
  input  logic       id_md_use,
  output logic       stall,
  output logic       bubble_e,
  output logic       md_busy,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel
);

  logic [4:0] dst_e_q, dst_e_d, dst_m_q, dst_m_d, dst_w_q, dst_w_d;
  logic [1:0] tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       data_stall, md_stall, advance;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // tuse of 3 marks an operand the instruction does not read
  function automatic logic data_haz(input logic [4:0] x, input logic [1:0] tuse,
                                    input logic [4:0] de, input logic [1:0] te,
                                    input logic [4:0] dm, input logic [1:0] tm);
    if (x == 5'd0 || tuse == 2'd3) return 1'b0;
    return ((x == de) && (te > tuse)) || ((x == dm) && (tm > tuse));
  endfunction

  // Only the newest matching stage may forward; an unready match blocks older ones
  function automatic logic [1:0] fwd_sel(input logic [4:0] x,
                                         input logic [4:0] de, input logic [1:0] te,
                                         input logic [4:0] dm, input logic [1:0] tm,
                                         input logic [4:0] dw);
    if (x == 5'd0) return 2'd0;
    if (x == de) return (te == 2'd0) ? 2'd1 : 2'd0;
    if (x == dm) return (tm == 2'd0) ? 2'd2 : 2'd0;
    if (x == dw) return 2'd3;
    return 2'd0;
  endfunction

  always_comb begin
    data_stall = data_haz(id_rs, id_rs_tuse, dst_e_q, tnew_e_q, dst_m_q, tnew_m_q) |
                 data_haz(id_rt, id_rt_tuse, dst_e_q, tnew_e_q, dst_m_q, tnew_m_q);
    md_stall   = (id_md_start | id_md_use) & (md_cnt_q != 4'd0);
    stall      = id_valid & (data_stall | md_stall);
    bubble_e   = stall;
    md_busy    = (md_cnt_q != 4'd0);
    fwd_rs_sel = fwd_sel(id_rs, dst_e_q, tnew_e_q, dst_m_q, tnew_m_q, dst_w_q);
    fwd_rt_sel = fwd_sel(id_rt, dst_e_q, tnew_e_q, dst_m_q, tnew_m_q, dst_w_q);
    advance    = id_valid & ~stall;

    dst_w_d  = dst_m_q;
    dst_m_d  = dst_e_q;
    tnew_m_d = sat_dec(tnew_e_q);
    dst_e_d  = advance ? id_dst  : 5'd0;
    tnew_e_d = advance ? id_tnew : 2'd0;

    md_cnt_d = md_cnt_q;
    if (md_cnt_q != 4'd0)
      md_cnt_d = md_cnt_q - 4'd1;
    else if (advance && id_md_start)
      md_cnt_d = id_md_div ? 4'(DIV_LAT) : 4'(MULT_LAT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dst_e_q  <= 5'd0;
      dst_m_q  <= 5'd0;
      dst_w_q  <= 5'd0;
      tnew_e_q <= 2'd0;
      tnew_m_q <= 2'd0;
      md_cnt_q <= 4'd0;
    end else begin
      dst_e_q  <= dst_e_d;
      dst_m_q  <= dst_m_d;
      dst_w_q  <= dst_w_d;
      tnew_e_q <= tnew_e_d;
      tnew_m_q <= tnew_m_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: random traffic against an instruction-history model,
// plus directed hazard sequences with literal expectations.
module tb_hazard_ctrl;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic [1:0] id_rs_tuse = 2'd3, id_rt_tuse = 2'd3, id_tnew = '0;
  logic       id_md_start = 1'b0, id_md_div = 1'b0, id_md_use = 1'b0;
  logic       stall, bubble_e, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_tuse(id_rs_tuse), .id_rt_tuse(id_rt_tuse),
    .id_dst(id_dst), .id_tnew(id_tnew), .id_md_start(id_md_start),
    .id_md_div(id_md_div), .id_md_use(id_md_use),
    .stall(stall), .bubble_e(bubble_e), .md_busy(md_busy),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: history of the last three issued instructions (index 0 = newest = E).
  // Each keeps the Tnew it had on entering E; its remaining Tnew shrinks with age.
  int  m_dst[3];
  int  m_tn[3];
  int  cyc = 0;
  int  busy_until = 0;
  bit  started = 0;

  function automatic int eff_tnew(input int s);
    return (m_tn[s] - s > 0) ? m_tn[s] - s : 0;
  endfunction

  function automatic bit m_haz(input int x, input int tuse);
    if (x == 0 || tuse == 3) return 0;
    for (int s = 0; s < 2; s++)
      if (m_dst[s] == x && eff_tnew(s) > tuse) return 1;
    return 0;
  endfunction

  function automatic int m_sel(input int x);
    if (x == 0) return 0;
    for (int s = 0; s < 3; s++)
      if (m_dst[s] == x) return (s == 2 || eff_tnew(s) == 0) ? s + 1 : 0;
    return 0;
  endfunction

  function automatic bit m_busy();
    return cyc < busy_until;
  endfunction

  function automatic bit m_stall();
    bit ds, ms;
    ds = m_haz(id_rs, id_rs_tuse) || m_haz(id_rt, id_rt_tuse);
    ms = (id_md_start || id_md_use) && m_busy();
    return id_valid && (ds || ms);
  endfunction

  always @(posedge clk) begin
    bit adv;
    started = 1;
    if (!reset) begin
      for (int s = 0; s < 3; s++) begin m_dst[s] = 0; m_tn[s] = 0; end
      cyc++;
      busy_until = 0;
    end else begin
      adv = id_valid && !m_stall();
      cyc++;
      if (adv && id_md_start) busy_until = cyc + (id_md_div ? DIV_LAT : MULT_LAT);
      m_dst[2] = m_dst[1];
      m_dst[1] = m_dst[0]; m_tn[1] = m_tn[0];
      m_dst[0] = adv ? int'(id_dst) : 0;
      m_tn[0]  = adv ? int'(id_tnew) : 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_stall",  stall,      m_stall());
      chk("model_bubble", bubble_e,   m_stall());
      chk("model_busy",   md_busy,    m_busy());
      chk("model_rs_sel", fwd_rs_sel, m_sel(id_rs));
      chk("model_rt_sel", fwd_rt_sel, m_sel(id_rt));
    end
  end

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] rstu, input logic [1:0] rttu,
                       input logic [4:0] dst, input logic [1:0] tn,
                       input logic ms, input logic md, input logic mu);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_tuse = rstu; id_rt_tuse = rttu;
    id_dst = dst; id_tnew = tn; id_md_start = ms; id_md_div = md; id_md_use = mu;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    adv();
  endtask

  // Holds the current ID instruction until it stops stalling; leaves time at the
  // negedge where stall was seen low.
  task automatic hold_count(input string nm, input int exp, output bit first_busy);
    int n = 0;
    bit first = 1;
    first_busy = 0;
    forever begin
      @(negedge clk);
      if (first) first_busy = md_busy;
      first = 0;
      if (!stall) break;
      if (n >= 40) begin
        $display("FAIL %s: stall never released", nm);
        break;
      end
      n++;
      @(posedge clk); #1;
    end
    chk(nm, n, exp);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'd31;
    endcase
  endfunction

  initial begin
    bit b;
    // reset held two cycles with random ID inputs
    reset = 1'b0;
    repeat (2) begin
      drive($urandom_range(1), pick_reg(), pick_reg(), 2'($urandom_range(3)),
            2'($urandom_range(3)), pick_reg(), 2'($urandom_range(2)),
            $urandom_range(1), $urandom_range(1), $urandom_range(1));
      adv();
    end
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_rs_sel", fwd_rs_sel, 0);
    chk("rst_rt_sel", fwd_rt_sel, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) nop();

    // lw $8 ; beq $8,$9
    drive(1, 0, 0, 3, 3, 8, 2, 0, 0, 0); adv();
    drive(1, 8, 9, 0, 0, 0, 0, 0, 0, 0);
    hold_count("lw_beq_stalls", 2, b);
    chk("lw_beq_rs_sel", fwd_rs_sel, 3);
    chk("lw_beq_rt_sel", fwd_rt_sel, 0);
    adv(); repeat (3) nop();

    // lw $8 ; addu using $8 ; then lw ; sw-data
    drive(1, 0, 0, 3, 3, 8, 2, 0, 0, 0); adv();
    drive(1, 8, 0, 1, 3, 10, 1, 0, 0, 0);
    hold_count("lw_alu_stalls", 1, b);
    adv(); repeat (3) nop();
    drive(1, 0, 0, 3, 3, 8, 2, 0, 0, 0); adv();
    drive(1, 0, 8, 1, 2, 0, 0, 0, 0, 0);
    hold_count("lw_sw_stalls", 0, b);
    adv(); repeat (3) nop();

    // addu $8 ; addu $8
    drive(1, 0, 0, 1, 1, 8, 1, 0, 0, 0); adv();
    drive(1, 8, 0, 1, 1, 10, 1, 0, 0, 0);
    hold_count("alu_alu_stalls", 0, b);
    chk("alu_alu_rs_sel", fwd_rs_sel, 0);
    adv(); repeat (3) nop();
    // addu $8 ; nop ; beq $8
    drive(1, 0, 0, 1, 1, 8, 1, 0, 0, 0); adv();
    nop();
    drive(1, 8, 0, 0, 3, 0, 0, 0, 0, 0);
    hold_count("alu_nop_beq_stalls", 0, b);
    chk("alu_nop_beq_rs_sel", fwd_rs_sel, 2);
    adv(); repeat (3) nop();
    // addu $8 ; beq $8
    drive(1, 0, 0, 1, 1, 8, 1, 0, 0, 0); adv();
    drive(1, 8, 0, 0, 3, 0, 0, 0, 0, 0);
    hold_count("alu_beq_stalls", 1, b);
    chk("alu_beq_rs_sel", fwd_rs_sel, 2);
    adv(); repeat (3) nop();

    // jal ; jr $31
    drive(1, 0, 0, 3, 3, 31, 0, 0, 0, 0); adv();
    drive(1, 31, 0, 0, 3, 0, 0, 0, 0, 0);
    hold_count("jal_jr_stalls", 0, b);
    chk("jal_jr_rs_sel", fwd_rs_sel, 1);
    adv(); repeat (3) nop();

    // div ; mflo, then mult ; mfhi
    drive(1, 8, 9, 1, 1, 0, 0, 1, 1, 0); adv();
    drive(1, 0, 0, 3, 3, 8, 1, 0, 0, 1);
    hold_count("div_mflo_stalls", DIV_LAT, b);
    chk("div_busy", b, 1);
    adv();
    drive(1, 8, 9, 1, 1, 0, 0, 1, 0, 0); adv();
    drive(1, 0, 0, 3, 3, 9, 1, 0, 0, 1);
    hold_count("mult_mfhi_stalls", MULT_LAT, b);
    adv(); repeat (3) nop();

    // write to $0 ; beq $0,$0
    drive(1, 0, 0, 3, 3, 0, 2, 0, 0, 0); adv();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    hold_count("zero_stalls", 0, b);
    chk("zero_rs_sel", fwd_rs_sel, 0);
    chk("zero_rt_sel", fwd_rt_sel, 0);
    adv();

    // reset in the middle of a divide
    drive(1, 8, 9, 1, 1, 0, 0, 1, 1, 0); adv();
    repeat (4) nop();
    @(negedge clk);
    chk("middiv_busy_before", md_busy, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("middiv_busy_after", md_busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(199) != 0);
      drive($urandom_range(9) != 0, pick_reg(), pick_reg(),
            2'($urandom_range(3)), 2'($urandom_range(3)), pick_reg(),
            2'($urandom_range(2)), $urandom_range(7) == 0, $urandom_range(1),
            $urandom_range(5) == 0);
      adv();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
